// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative RV32M execution unit for the EX stage. Accepts one M-extension op
// (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), runs a fixed DATA_WIDTH-step
// shift-add multiply or restoring divide on operand magnitudes, applies the
// sign fix on the last step and presents a one-cycle done pulse. Divide by
// zero and signed overflow bypass the loop and finish the next cycle.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous, active-high reset
//   start   in   EX holds a valid M-extension op
//   flush   in   EX squash; abandons any op in flight
//   funct3  in   op select (000 mul .. 111 remu)
//   op_a    in   rs1 value
//   op_b    in   rs2 value
//   busy    out  iteration loop in progress
//   stall   out  hold IF/ID/EX
//   done    out  result valid this cycle (one-cycle pulse)
//   result  out  registered result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LOOP_CNT = CW'(DATA_WIDTH);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_q, neg_d;       // result needs negation at the end
  logic [W-1:0]    acc_q, acc_d;       // product high half / partial remainder
  logic [W-1:0]    lo_q, lo_d;         // multiplier->product low / dividend->quotient
  logic [W-1:0]    mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [W-1:0]    result_q, result_d;

  // Operand decode on the incoming op
  logic            signed_a, signed_b, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic            div_zero, div_ovf, fast_path;
  logic [W-1:0]    fast_val;
  logic            accept;

  // One iteration step on the latched state
  logic [W:0]      mul_sum;
  logic [W:0]      rem_shift;
  logic            div_ge;
  logic [W-1:0]    div_diff;
  logic [W-1:0]    step_acc, step_lo;

  // Sign fix and result select for the final step
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    quo_fix, rem_fix, final_val;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3)
      3'b001:         begin signed_a = 1'b1; signed_b = 1'b1; end  // mulh
      3'b010:         begin signed_a = 1'b1; signed_b = 1'b0; end  // mulhsu
      3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end  // div, rem
      default:        begin signed_a = 1'b0; signed_b = 1'b0; end
    endcase
    a_neg = signed_a & op_a[W-1];
    b_neg = signed_b & op_b[W-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;

    // Fast paths only apply to the divide group (funct3[2]); overflow only to
    // the signed forms (funct3[0] == 0).
    div_zero  = (op_b == '0);
    div_ovf   = ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    fast_path = funct3[2] & (div_zero | div_ovf);
    if (div_zero) fast_val = funct3[1] ? op_a : '1;
    else          fast_val = funct3[1] ? '0   : op_a;

    accept = (state_q == IDLE) & start & ~flush;

    // Shift-add: add multiplicand into the high half when the low bit is set,
    // then shift the whole 2W product right by one.
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. The difference is below the divisor,
    // so its low W bits are exact.
    rem_shift = {acc_q, lo_q[W-1]};
    div_ge    = (rem_shift >= {1'b0, mcand_q});
    div_diff  = rem_shift[W-1:0] - mcand_q;

    if (funct3_q[2]) begin
      step_acc = div_ge ? div_diff : rem_shift[W-1:0];
      step_lo  = {lo_q[W-2:0], div_ge};
    end else begin
      step_acc = mul_sum[W:1];
      step_lo  = {mul_sum[0], lo_q[W-1:1]};
    end

    // neg_q already encodes the op-specific rule (product/quotient: signs
    // differ; remainder: dividend sign), so one flag serves every op.
    prod     = {step_acc, step_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_acc : step_acc;
    case (funct3_q)
      3'b000:                 final_val = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*W-1:W];
      3'b100, 3'b101:         final_val = quo_fix;
      default:                final_val = rem_fix;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    done     = 1'b0;
    busy     = (state_q == CALC);
    stall    = accept | (state_q == CALC);

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = funct3;
          acc_d    = '0;
          lo_d     = funct3[2] ? a_mag : b_mag;
          mcand_d  = funct3[2] ? b_mag : a_mag;
          case (funct3)
            3'b001, 3'b010, 3'b100: neg_d = a_neg ^ b_neg;
            3'b110:                 neg_d = a_neg;
            default:                neg_d = 1'b0;
          endcase
          if (fast_path) begin
            result_d = fast_val;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d    = LOOP_CNT;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = final_val;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A squash abandons the op in flight and leaves the last result intact.
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
      done     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M execution unit and sequencer in the EX stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op from the decoder (opcode R, funct7 = 0000001).
- Runs a 32-step shift-add or restoring-divide loop and stalls the pipeline until the result is ready.
- Presents a one-cycle done pulse with a 32-bit result for writeback.

Parameters:
- DATA_WIDTH, 32, operand/result width; loop count equals DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  EX holds a valid M-extension op.
- flush  in  1  EX squash (branch/exception/mret).
- funct3  in  3  op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- op_a  in  DATA_WIDTH  rs1 value (forwarded).
- op_b  in  DATA_WIDTH  rs2 value (forwarded).
- busy  out  1  loop in progress.
- stall  out  1  hold IF/ID/EX.
- done  out  1  result valid this cycle.
- result  out  DATA_WIDTH  result to WB mux.

Behaviour:
- Reset values: state IDLE; busy = 0; done = 0; result = 0; stall = 0; internal counter, accumulators and latched funct3 cleared.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start & ~flush:
  - latch funct3;
  - latch magnitudes |a| and |b| as the signedness of the op requires (mulhsu: a signed, b unsigned; divu/remu/mulhu: both unsigned);
  - latch result sign flags;
  - counter = DATA_WIDTH.
- IDLE -> DONE directly (fast path, no CALC) on start & ~flush with a div-type op and either condition below:
  - divide by zero (op_b = 0): div/divu quotient = all ones (0xFFFFFFFF); rem/remu = op_a.
  - signed overflow (div/rem, op_a = 0x80000000, op_b = 0xFFFFFFFF): div = 0x80000000; rem = 0.
- CALC, multiply: one shift-add step per cycle on a 2*DATA_WIDTH product.
- CALC, divide: one restoring step per cycle (shift remainder left, subtract divisor, set quotient bit if non-negative).
- CALC: counter decrements each cycle; at counter = 1 the next state is DONE and the final sign fix is applied.
- Sign fix:
  - product negated if signs differ (mulh/mulhsu only);
  - quotient negated if operand signs differ (div);
  - remainder takes the sign of the dividend (rem).
- Result select:
  - mul: product[31:0];
  - mulh/mulhsu/mulhu: product[63:32];
  - div/divu: quotient;
  - rem/remu: remainder.
- DONE: done = 1 for exactly one cycle; result registered and held stable until the next accepted start. DONE -> IDLE unconditionally.
- stall = (state == IDLE & start & ~flush) | (state == CALC). stall = 0 in DONE so the pipeline advances and captures the result the same cycle.
- busy = (state == CALC).
- Latency: start sampled high in IDLE at cycle N.
  - Normal op: done high at cycle N+33 (CALC cycles N+1..N+32).
  - Fast path: done high at N+1.
- start while CALC or DONE is ignored: no restart and no operand re-latch.
- Operand/funct3 changes during CALC have no effect (latched values are used).
- flush in any state: next state IDLE, counter cleared, no done pulse. result keeps its previous value.
- flush and start in the same cycle in IDLE: flush wins, op not accepted, stall = 0.
- A back-to-back M op: start high in IDLE the cycle after DONE is accepted normally.
- rst mid-CALC: returns to IDLE next edge with all outputs at reset values.
- The loop count is fixed regardless of operand values; there is no early termination except the fast paths.

Test Plan:
- mul, op_a = 7, op_b = 0xFFFFFFFA (-6) -> stall high cycles N..N+32, done at N+33, result = 0xFFFFFFD6 (-42).
- mulh, op_a = 0x80000000, op_b = 0x80000000 -> result = 0x40000000. mulhu with the same operands -> 0x40000000. mulhsu, op_a = 0xFFFFFFFF, op_b = 0xFFFFFFFF -> 0xFFFFFFFF.
- div, op_a = -7, op_b = 2 -> result 0xFFFFFFFD (-3). rem with the same operands -> 0xFFFFFFFF (-1). divu, 100 / 7 -> 14. remu, 100 / 7 -> 2.
- Divide by zero: divu, op_a = 5, op_b = 0 -> done at N+1, result 0xFFFFFFFF. rem, op_a = 5, op_b = 0 -> 5. Overflow: div, op_a = 0x80000000, op_b = -1 -> done at N+1, result 0x80000000.
- flush asserted at CALC cycle 10 -> IDLE next cycle, no done pulse, stall low. A new start two cycles later completes correctly with fresh operands.
- Operands changed and start held high during CALC -> result reflects the originally latched operands. A second start the cycle after DONE yields a second done 33 cycles later.
